merge_2x1_rr: RTL

- Downstream recombiner for the 1x2 demultiplexer stage. Takes the two demux output channels and merges them back into one stream.
- Each input channel has a valid/ready handshake and a 2-entry FIFO. A round-robin arbiter selects between the FIFOs, and a registered output stage drives the merged stream with a source tag.
- Sits directly after the 1x2 demux in the datapath.

---
 rtl/merge_pkg.sv | 16 +
 rtl/merge_2x1_rr_if.sv | 28 ++
 rtl/merge_2x1_rr_fifo.sv | 48 ++++
 rtl/merge_2x1_rr.sv | 68 ++++++
 4 files changed

// File: rtl/merge_pkg.sv
// Shared constants and channel-id type for the 2:1 round-robin merge.
package merge_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = 1;

    typedef logic [0:0] src_t;

    localparam src_t SRC_CH0 = 1'b0;
    localparam src_t SRC_CH1 = 1'b1;

    function automatic src_t other_src(input src_t s);
        return (s == SRC_CH0) ? SRC_CH1 : SRC_CH0;
    endfunction

endpackage

// File: rtl/merge_2x1_rr_if.sv
// Two valid/ready input channels plus the tagged merged output stream.
interface merge_2x1_rr_if import merge_pkg::*; #(parameter int WIDTH = 8);

    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    src_t             out_src;
    logic             out_ready;

    // master: the surrounding datapath (demux side and consumer side)
    modport master (
        output in0_valid, in0_data, input in0_ready,
        output in1_valid, in1_data, input in1_ready,
        input  out_valid, out_data, out_src, output out_ready
    );

    modport slave (
        input  in0_valid, in0_data, output in0_ready,
        input  in1_valid, in1_data, output in1_ready,
        output out_valid, out_data, out_src, input out_ready
    );

endinterface

// File: rtl/merge_2x1_rr_fifo.sv
// Two-entry FIFO, head visible combinationally; push ignored when full, no full-bypass.
// Caller guarantees pop only when non-empty.
module fifo_2deep import merge_pkg::*; #(parameter int WIDTH = 8) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       count;
    logic             do_push;

    assign do_push   = push && !full;
    assign empty     = (count == 2'd0);
    assign full      = (count == FULL_CNT);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset: count gates what is ever read out
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/merge_2x1_rr.sv
// 2:1 round-robin merge: per-channel 2-deep FIFO, registered tagged output, 2-cycle latency.
// Output stalls hold data/src and stop pops; full FIFOs drop inN_ready.
module merge_2x1_rr import merge_pkg::*; #(parameter int WIDTH = 8) (
    input  logic           clk,
    input  logic           rst,
    merge_2x1_rr_if.slave  bus
);

    logic             push0, push1;
    logic             pop0, pop1;
    logic [WIDTH-1:0] head0, head1;
    logic             empty0, empty1;
    logic             full0, full1;
    logic             load;
    src_t             grant;
    src_t             last_grant;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    src_t             out_src_q;

    assign bus.in0_ready = !rst && !full0;
    assign bus.in1_ready = !rst && !full1;
    assign push0 = bus.in0_valid && bus.in0_ready;
    assign push1 = bus.in1_valid && bus.in1_ready;

    fifo_2deep #(.WIDTH(WIDTH)) u_fifo0 (
        .clk(clk), .rst(rst), .push(push0), .push_data(bus.in0_data),
        .pop(pop0), .head_data(head0), .empty(empty0), .full(full0)
    );

    fifo_2deep #(.WIDTH(WIDTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push1), .push_data(bus.in1_data),
        .pop(pop1), .head_data(head1), .empty(empty1), .full(full1)
    );

    assign load = (!out_valid_q || bus.out_ready) && (!empty0 || !empty1);

    always_comb begin
        grant = SRC_CH0;
        if (empty0)      grant = SRC_CH1;
        else if (empty1) grant = SRC_CH0;
        else             grant = other_src(last_grant);
    end

    assign pop0 = load && (grant == SRC_CH0);
    assign pop1 = load && (grant == SRC_CH1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC_CH0;
            last_grant  <= SRC_CH1;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= (grant == SRC_CH0) ? head0 : head1;
            out_src_q   <= grant;
            last_grant  <= grant;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule
